// File: rtl/layer_ctrl_rx_isolation_buffer.sv
// layer_ctrl_rx_isolation_buffer
//   Receive path between the MBus controller and a layer controller (LC).
//   Incoming RX words are acknowledged towards MBus and stored in a small
//   FIFO. They are acked and stored even while the LC is isolated. The head
//   entry is replayed to the LC with a 4-phase handshake once isolation is
//   released. Every LC-facing output is forced to 0 while the LC is isolated.
module layer_ctrl_rx_isolation_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              LC_ISOLATION,
   input  logic [ADDR_W-1:0] RX_ADDR_FROM_MBUS,
   input  logic [DATA_W-1:0] RX_DATA_FROM_MBUS,
   input  logic              RX_PEND_FROM_MBUS,
   input  logic              RX_BROADCAST_FROM_MBUS,
   input  logic              RX_REQ_FROM_MBUS,
   output logic              RX_ACK_TO_MBUS,
   input  logic              RX_FAIL_FROM_MBUS,
   input  logic              TX_ACK_FROM_MBUS,
   input  logic              TX_SUCC_FROM_MBUS,
   input  logic              TX_FAIL_FROM_MBUS,
   output logic [ADDR_W-1:0] RX_ADDR_TO_LC,
   output logic [DATA_W-1:0] RX_DATA_TO_LC,
   output logic              RX_PEND_TO_LC,
   output logic              RX_BROADCAST_TO_LC,
   output logic              RX_REQ_TO_LC,
   input  logic              RX_ACK_FROM_LC,
   output logic              RX_FAIL_TO_LC,
   output logic              TX_ACK_TO_LC,
   output logic              TX_SUCC_TO_LC,
   output logic              TX_FAIL_TO_LC,
   output logic              OVERFLOW_TO_LC,
   input  logic              CLR_OVERFLOW_FROM_LC,
   output logic [CNT_W-1:0]  PENDING_CNT
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Ingress (MBus side) states
   localparam logic [0:0] I_IDLE = 1'b0;
   localparam logic [0:0] I_ACK  = 1'b1;

   // Egress (LC side) states
   localparam logic [1:0] E_IDLE = 2'd0;
   localparam logic [1:0] E_REQ  = 2'd1;
   localparam logic [1:0] E_WAIT = 2'd2;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              pend;
      logic              bcast;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           wr_entry;
   entry_t           head;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [0:0]       i_state_q, i_state_d;
   logic [1:0]       e_state_q, e_state_d;
   logic             ovf_q, ovf_d;
   logic             rx_fail_q, tx_ack_q, tx_succ_q, tx_fail_q;

   logic             push, pop, full, empty;
   logic             ovf_set, clr_eff, lc_ack_eff, lc_valid;

   assign full       = (cnt_q == CNT_FULL);
   assign empty      = (cnt_q == '0);
   // The LC's own inputs are meaningless while it is held in isolation.
   assign lc_ack_eff = RX_ACK_FROM_LC & ~LC_ISOLATION;
   assign clr_eff    = CLR_OVERFLOW_FROM_LC & ~LC_ISOLATION;

   assign wr_entry = '{addr:  RX_ADDR_FROM_MBUS,
                       data:  RX_DATA_FROM_MBUS,
                       pend:  RX_PEND_FROM_MBUS,
                       bcast: RX_BROADCAST_FROM_MBUS};
   assign head     = mem_q[rd_ptr_q];

   // Ingress FSM: accept MBus words into the FIFO, drop only when full and isolated
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      i_state_d = i_state_q;
      push      = 1'b0;
      ovf_set   = 1'b0;
      case (i_state_q)
         I_IDLE: begin
            if (RX_REQ_FROM_MBUS) begin
               if (!full) begin
                  push      = 1'b1;
                  i_state_d = I_ACK;
               end else if (LC_ISOLATION) begin
                  // The LC cannot drain the FIFO, so stalling MBus would hang the bus.
                  ovf_set   = 1'b1;
                  i_state_d = I_ACK;
               end
            end
         end
         I_ACK: begin
            if (!RX_REQ_FROM_MBUS) i_state_d = I_IDLE;
         end
         default: i_state_d = I_IDLE;
      endcase
   end

   // Egress FSM: present the head entry to the LC and pop on its ack
   always_comb begin
      e_state_d = e_state_q;
      pop       = 1'b0;
      case (e_state_q)
         E_IDLE: begin
            if (!empty && !LC_ISOLATION) e_state_d = E_REQ;
         end
         E_REQ: begin
            if (LC_ISOLATION) begin
               // Abort without popping; the entry is replayed after release.
               e_state_d = E_IDLE;
            end else if (lc_ack_eff) begin
               pop       = 1'b1;
               e_state_d = E_WAIT;
            end
         end
         E_WAIT: begin
            if (!lc_ack_eff) e_state_d = E_IDLE;
         end
         default: e_state_d = E_IDLE;
      endcase
   end

   // FIFO pointer/occupancy and sticky overflow next-state
   always_comb begin
      wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      // Set takes priority over a simultaneous clear.
      ovf_d = ovf_set | (ovf_q & ~clr_eff);
   end

   // Control state registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         i_state_q <= I_IDLE;
         e_state_q <= E_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         rx_fail_q <= 1'b0;
         tx_ack_q  <= 1'b0;
         tx_succ_q <= 1'b0;
         tx_fail_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         i_state_q <= i_state_d;
         e_state_q <= e_state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         rx_fail_q <= RX_FAIL_FROM_MBUS;
         tx_ack_q  <= TX_ACK_FROM_MBUS;
         tx_succ_q <= TX_SUCC_FROM_MBUS;
         tx_fail_q <= TX_FAIL_FROM_MBUS;
      end
   end

   // FIFO storage
   always_ff @(posedge CLK) begin
      // NOTE: storage is not reset; a flush resets the pointers and count, and
      // unread entries are never visible on the outputs.
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   // Output drive, with the isolation clamp on every LC-facing signal
   assign lc_valid           = (e_state_q == E_REQ) & ~LC_ISOLATION;
   assign RX_REQ_TO_LC       = lc_valid;
   assign RX_ADDR_TO_LC      = lc_valid ? head.addr  : '0;
   assign RX_DATA_TO_LC      = lc_valid ? head.data  : '0;
   assign RX_PEND_TO_LC      = lc_valid & head.pend;
   assign RX_BROADCAST_TO_LC = lc_valid & head.bcast;
   assign RX_FAIL_TO_LC      = rx_fail_q & ~LC_ISOLATION;
   assign TX_ACK_TO_LC       = tx_ack_q  & ~LC_ISOLATION;
   assign TX_SUCC_TO_LC      = tx_succ_q & ~LC_ISOLATION;
   assign TX_FAIL_TO_LC      = tx_fail_q & ~LC_ISOLATION;
   assign OVERFLOW_TO_LC     = ovf_q     & ~LC_ISOLATION;
   assign RX_ACK_TO_MBUS     = (i_state_q == I_ACK);
   assign PENDING_CNT        = cnt_q;

endmodule

// File: tb/tb_layer_ctrl_rx_isolation_buffer.sv
// tb_layer_ctrl_rx_isolation_buffer
//   Directed bench for the MBus-to-LC receive buffer with isolation support.
module tb_layer_ctrl_rx_isolation_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        iso;
   logic [31:0] m_addr, m_data;
   logic        m_pend, m_bcast, m_req;
   logic        rx_ack_to_mbus;
   logic        rx_fail_in, tx_ack_in, tx_succ_in, tx_fail_in;
   logic [31:0] lc_addr, lc_data;
   logic        lc_pend, lc_bcast, lc_req;
   logic        lc_ack;
   logic        rx_fail_lc, tx_ack_lc, tx_succ_lc, tx_fail_lc;
   logic        ovf_lc;
   logic        clr_ovf;
   logic [2:0]  pend_cnt;

   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   layer_ctrl_rx_isolation_buffer #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(4), .CNT_W(3)
   ) dut (
      .CLK                    (clk),
      .RESET                  (rst),
      .LC_ISOLATION           (iso),
      .RX_ADDR_FROM_MBUS      (m_addr),
      .RX_DATA_FROM_MBUS      (m_data),
      .RX_PEND_FROM_MBUS      (m_pend),
      .RX_BROADCAST_FROM_MBUS (m_bcast),
      .RX_REQ_FROM_MBUS       (m_req),
      .RX_ACK_TO_MBUS         (rx_ack_to_mbus),
      .RX_FAIL_FROM_MBUS      (rx_fail_in),
      .TX_ACK_FROM_MBUS       (tx_ack_in),
      .TX_SUCC_FROM_MBUS      (tx_succ_in),
      .TX_FAIL_FROM_MBUS      (tx_fail_in),
      .RX_ADDR_TO_LC          (lc_addr),
      .RX_DATA_TO_LC          (lc_data),
      .RX_PEND_TO_LC          (lc_pend),
      .RX_BROADCAST_TO_LC     (lc_bcast),
      .RX_REQ_TO_LC           (lc_req),
      .RX_ACK_FROM_LC         (lc_ack),
      .RX_FAIL_TO_LC          (rx_fail_lc),
      .TX_ACK_TO_LC           (tx_ack_lc),
      .TX_SUCC_TO_LC          (tx_succ_lc),
      .TX_FAIL_TO_LC          (tx_fail_lc),
      .OVERFLOW_TO_LC         (ovf_lc),
      .CLR_OVERFLOW_FROM_LC   (clr_ovf),
      .PENDING_CNT            (pend_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full 4-phase MBus transfer: raise req, wait for ack, drop req, wait for ack to fall.
   task automatic mbus_push(input logic [31:0] a, input logic [31:0] d,
                            input logic p, input logic b, input string tag);
      m_addr = a; m_data = d; m_pend = p; m_bcast = b; m_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rx_ack_to_mbus) break;
      end
      check({tag, "_ack"}, 64'(rx_ack_to_mbus), 64'd1);
      m_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!rx_ack_to_mbus) break;
      end
      check({tag, "_ackfall"}, 64'(rx_ack_to_mbus), 64'd0);
   endtask

   // LC side: wait for a request, compare the presented entry, ack and release.
   task automatic lc_pop(input logic [31:0] a, input logic [31:0] d,
                         input logic p, input logic b, input string tag);
      for (int i = 0; i < 20; i++) begin
         if (lc_req) break;
         tick();
      end
      check({tag, "_req"},   64'(lc_req),   64'd1);
      check({tag, "_addr"},  64'(lc_addr),  64'(a));
      check({tag, "_data"},  64'(lc_data),  64'(d));
      check({tag, "_pend"},  64'(lc_pend),  64'(p));
      check({tag, "_bcast"}, 64'(lc_bcast), 64'(b));
      lc_ack = 1'b1;
      tick();
      check({tag, "_reqfall"}, 64'(lc_req), 64'd0);
      lc_ack = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; iso = 1'b0;
      m_addr = '0; m_data = '0; m_pend = 1'b0; m_bcast = 1'b0; m_req = 1'b0;
      rx_fail_in = 1'b0; tx_ack_in = 1'b0; tx_succ_in = 1'b0; tx_fail_in = 1'b0;
      lc_ack = 1'b0; clr_ovf = 1'b0;

      // Reset state
      #3;
      check("rst_ack",  64'(rx_ack_to_mbus), 64'd0);
      check("rst_req",  64'(lc_req),         64'd0);
      check("rst_addr", 64'(lc_addr),        64'd0);
      check("rst_data", 64'(lc_data),        64'd0);
      check("rst_ovf",  64'(ovf_lc),         64'd0);
      check("rst_cnt",  64'(pend_cnt),       64'd0);
      check("rst_txs",  64'(tx_succ_lc),     64'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // T1: single message, not isolated, exact latency
      m_addr = 32'h12; m_data = 32'hDEADBEEF; m_pend = 1'b1; m_bcast = 1'b0; m_req = 1'b1;
      tick();
      check("t1_ack_e1",  64'(rx_ack_to_mbus), 64'd1);
      check("t1_cnt_e1",  64'(pend_cnt),       64'd1);
      check("t1_req_e1",  64'(lc_req),         64'd0);
      tick();
      check("t1_req_e2",  64'(lc_req),  64'd1);
      check("t1_addr_e2", 64'(lc_addr), 64'h12);
      check("t1_data_e2", 64'(lc_data), 64'hDEADBEEF);
      check("t1_pend_e2", 64'(lc_pend), 64'd1);
      m_req = 1'b0; lc_ack = 1'b1;
      tick();
      check("t1_ackfall", 64'(rx_ack_to_mbus), 64'd0);
      check("t1_reqfall", 64'(lc_req),         64'd0);
      check("t1_cnt0",    64'(pend_cnt),       64'd0);
      lc_ack = 1'b0;
      tick();

      // Status pulse: one-cycle register, cleared the next cycle
      tx_succ_in = 1'b1;
      tick();
      check("st_txs_on",  64'(tx_succ_lc), 64'd1);
      check("st_txa_off", 64'(tx_ack_lc),  64'd0);
      tx_succ_in = 1'b0; rx_fail_in = 1'b1;
      tick();
      check("st_txs_off", 64'(tx_succ_lc), 64'd0);
      check("st_rxf_on",  64'(rx_fail_lc), 64'd1);
      rx_fail_in = 1'b0;
      tick();

      // T2: isolated, three messages buffered, outputs clamped, then replay in order
      iso = 1'b1;
      mbus_push(32'h100, 32'h11111111, 1'b1, 1'b0, "t2_m0");
      mbus_push(32'h104, 32'h22222222, 1'b0, 1'b1, "t2_m1");
      mbus_push(32'h108, 32'hCAFEF00D, 1'b1, 1'b1, "t2_m2");
      tx_fail_in = 1'b1;
      tick();
      tx_fail_in = 1'b0;
      check("t2_cnt3",   64'(pend_cnt),   64'd3);
      check("t2_req0",   64'(lc_req),     64'd0);
      check("t2_addr0",  64'(lc_addr),    64'd0);
      check("t2_data0",  64'(lc_data),    64'd0);
      check("t2_txf0",   64'(tx_fail_lc), 64'd0);
      tick(); tick();
      check("t2_still0", 64'(lc_req), 64'd0);
      iso = 1'b0;
      lc_pop(32'h100, 32'h11111111, 1'b1, 1'b0, "t2_p0");
      lc_pop(32'h104, 32'h22222222, 1'b0, 1'b1, "t2_p1");
      lc_pop(32'h108, 32'hCAFEF00D, 1'b1, 1'b1, "t2_p2");
      check("t2_cnt0", 64'(pend_cnt), 64'd0);

      // T3: isolated overflow, clear ignored while isolated, cleared after release
      iso = 1'b1;
      mbus_push(32'h200, 32'hA0000000, 1'b0, 1'b0, "t3_m0");
      mbus_push(32'h204, 32'hA0000001, 1'b0, 1'b0, "t3_m1");
      mbus_push(32'h208, 32'hA0000002, 1'b0, 1'b0, "t3_m2");
      mbus_push(32'h20C, 32'hA0000003, 1'b0, 1'b0, "t3_m3");
      mbus_push(32'h210, 32'hA0000004, 1'b0, 1'b0, "t3_m4");
      check("t3_cnt4",    64'(pend_cnt), 64'd4);
      check("t3_ovf_iso", 64'(ovf_lc),   64'd0);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      iso = 1'b0;
      #1;
      check("t3_ovf_rel", 64'(ovf_lc), 64'd1);
      lc_pop(32'h200, 32'hA0000000, 1'b0, 1'b0, "t3_p0");
      lc_pop(32'h204, 32'hA0000001, 1'b0, 1'b0, "t3_p1");
      lc_pop(32'h208, 32'hA0000002, 1'b0, 1'b0, "t3_p2");
      lc_pop(32'h20C, 32'hA0000003, 1'b0, 1'b0, "t3_p3");
      tick();
      check("t3_noreplay", 64'(lc_req),   64'd0);
      check("t3_cnt0",     64'(pend_cnt), 64'd0);
      check("t3_ovf_held", 64'(ovf_lc),   64'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("t3_ovf_clr", 64'(ovf_lc), 64'd0);

      // T4: full while not isolated -> back-pressure until the LC pops one
      mbus_push(32'h300, 32'hB0000000, 1'b0, 1'b0, "t4_m0");
      mbus_push(32'h304, 32'hB0000001, 1'b0, 1'b0, "t4_m1");
      mbus_push(32'h308, 32'hB0000002, 1'b0, 1'b0, "t4_m2");
      mbus_push(32'h30C, 32'hB0000003, 1'b0, 1'b0, "t4_m3");
      check("t4_cnt4", 64'(pend_cnt), 64'd4);
      check("t4_req",  64'(lc_req),   64'd1);
      check("t4_head", 64'(lc_addr),  64'h300);
      m_addr = 32'h310; m_data = 32'hB0000004; m_pend = 1'b0; m_bcast = 1'b0; m_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_noack", 64'(rx_ack_to_mbus), 64'd0);
      end
      check("t4_noovf", 64'(ovf_lc), 64'd0);
      lc_ack = 1'b1;
      tick();
      check("t4_pop_ack0", 64'(rx_ack_to_mbus), 64'd0);
      check("t4_pop_cnt3", 64'(pend_cnt),       64'd3);
      lc_ack = 1'b0;
      tick();
      check("t4_ack1", 64'(rx_ack_to_mbus), 64'd1);
      check("t4_cnt4b", 64'(pend_cnt),      64'd4);
      m_req = 1'b0;
      tick();
      check("t4_ackfall", 64'(rx_ack_to_mbus), 64'd0);
      lc_pop(32'h304, 32'hB0000001, 1'b0, 1'b0, "t4_p1");
      lc_pop(32'h308, 32'hB0000002, 1'b0, 1'b0, "t4_p2");
      lc_pop(32'h30C, 32'hB0000003, 1'b0, 1'b0, "t4_p3");
      lc_pop(32'h310, 32'hB0000004, 1'b0, 1'b0, "t4_p4");
      check("t4_cnt0", 64'(pend_cnt), 64'd0);

      // T5: isolation rises during E_REQ -> request drops at once, entry kept
      mbus_push(32'h55, 32'h0BADF00D, 1'b0, 1'b1, "t5_m0");
      for (int i = 0; i < 20; i++) begin
         if (lc_req) break;
         tick();
      end
      check("t5_req_up", 64'(lc_req), 64'd1);
      iso = 1'b1;
      #1;
      check("t5_req_clamp",  64'(lc_req),  64'd0);
      check("t5_addr_clamp", 64'(lc_addr), 64'd0);
      tick();
      check("t5_cnt_kept", 64'(pend_cnt), 64'd1);
      tick();
      iso = 1'b0;
      lc_pop(32'h55, 32'h0BADF00D, 1'b0, 1'b1, "t5_p0");
      check("t5_cnt0", 64'(pend_cnt), 64'd0);

      // T6: reset while in I_ACK with two entries -> ack and count drop immediately
      iso = 1'b1;
      mbus_push(32'h600, 32'h66666666, 1'b0, 1'b0, "t6_m0");
      m_addr = 32'h604; m_data = 32'h77777777; m_req = 1'b1;
      tick();
      check("t6_ack_pre", 64'(rx_ack_to_mbus), 64'd1);
      check("t6_cnt_pre", 64'(pend_cnt),       64'd2);
      #1;
      rst = 1'b1;
      #1;
      check("t6_ack_rst", 64'(rx_ack_to_mbus), 64'd0);
      check("t6_cnt_rst", 64'(pend_cnt),       64'd0);
      m_req = 1'b0;
      tick();
      rst = 1'b0;
      iso = 1'b0;
      tick(); tick();
      check("t6_no_replay", 64'(lc_req),   64'd0);
      check("t6_cnt_after", 64'(pend_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
